// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache/memory interface: default widths, block size
// and the latency type used by fill controllers and benches.
package mem_if_pkg;

    localparam int DEF_ADDR_W      = 16;
    localparam int DEF_DATA_W      = 16;
    localparam int WORDS_PER_BLOCK = 8;
    localparam int MAX_LATENCY     = 8;

    typedef logic [3:0] latency_t;

endpackage

// File: rtl/mem_resp_pipe.sv
// LATENCY-stage valid+data delay line carrying read words to the response port.
// Data registers only load when their upstream stage is valid, so the output holds.
module mem_resp_pipe #(
    parameter int DATA_W  = 16,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o,
    output logic [LATENCY-1:0] stage_valid_o
);

    logic [LATENCY-1:0] valid_q;
    logic [DATA_W-1:0]  data_q [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            for (int k = 0; k < LATENCY; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            if (in_valid_i) begin
                data_q[0] <= in_data_i;
            end
            for (int k = 1; k < LATENCY; k++) begin
                valid_q[k] <= valid_q[k-1];
                if (valid_q[k-1]) begin
                    data_q[k] <= data_q[k-1];
                end
            end
        end
    end

    assign out_valid_o   = valid_q[LATENCY-1];
    assign out_data_o    = data_q[LATENCY-1];
    assign stage_valid_o = valid_q;

endmodule

// File: rtl/mem_responder.sv
// Main-memory responder: word-addressed storage with a fixed-latency pipelined
// read return and an occupancy counter of reads still in flight.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH_W = 15,
    parameter int LATENCY = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cache_MemRead,
    input  logic              cache_MemWrite,
    input  logic [ADDR_W-1:0] cache_mem_addr,
    input  logic [DATA_W-1:0] cache_mem_write_data,
    output logic              MemDataValid,
    output logic [DATA_W-1:0] mem_read_data,
    output logic [3:0]        rd_inflight
);

    localparam int WORDS = 1 << DEPTH_W;

    generate
        if (LATENCY < 1 || LATENCY > MAX_LATENCY) begin : g_bad_latency
            $error("mem_responder: LATENCY must be in 1..8");
        end
    endgenerate

    logic [DATA_W-1:0]  mem_q [WORDS];
    logic [DEPTH_W-1:0] word_idx;
    logic [DATA_W-1:0]  rd_word;
    logic [LATENCY-1:0] stage_valid;
    logic [3:0]         inflight_q;
    logic [3:0]         inflight_d;
    logic               unused_addr_lsb;

    assign word_idx        = cache_mem_addr[DEPTH_W:1];
    assign rd_word         = mem_q[word_idx];
    assign unused_addr_lsb = cache_mem_addr[0];

    // No reset on the array: contents must survive rst. The non-blocking write
    // gives read-first behaviour when a read and write hit the same word.
    always_ff @(posedge clk) begin
        if (cache_MemWrite) begin
            mem_q[word_idx] <= cache_mem_write_data;
        end
    end

    mem_resp_pipe #(
        .DATA_W  (DATA_W),
        .LATENCY (LATENCY)
    ) u_pipe (
        .clk           (clk),
        .rst_n         (rst),
        .in_valid_i    (cache_MemRead),
        .in_data_i     (rd_word),
        .out_valid_o   (MemDataValid),
        .out_data_o    (mem_read_data),
        .stage_valid_o (stage_valid)
    );

    always_comb begin
        inflight_d = inflight_q;
        if (cache_MemRead && !MemDataValid) begin
            inflight_d = inflight_q + 4'd1;
        end else if (!cache_MemRead && MemDataValid) begin
            inflight_d = inflight_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_q <= 4'd0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign rd_inflight = inflight_q;

    a_inflight_matches_stages: assert property (
        @(posedge clk) disable iff (!rst)
        $countones(stage_valid) == int'(inflight_q)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: reset, single reads, block fill, read/write
// collisions, reset mid-fill and odd-address aliasing, with hand-computed values.
module tb_mem_responder;
    import mem_if_pkg::*;

    localparam latency_t LAT = 4'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cache_MemRead = 1'b0;
    logic        cache_MemWrite = 1'b0;
    logic [15:0] cache_mem_addr = 16'h0;
    logic [15:0] cache_mem_write_data = 16'h0;
    logic        MemDataValid;
    logic [15:0] mem_read_data;
    logic [3:0]  rd_inflight;

    int testsRun = 0;
    int testsFailed = 0;

    mem_responder #(
        .ADDR_W  (16),
        .DATA_W  (16),
        .DEPTH_W (15),
        .LATENCY (int'(LAT))
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .cache_MemRead        (cache_MemRead),
        .cache_MemWrite       (cache_MemWrite),
        .cache_mem_addr       (cache_mem_addr),
        .cache_mem_write_data (cache_mem_write_data),
        .MemDataValid         (MemDataValid),
        .mem_read_data        (mem_read_data),
        .rd_inflight          (rd_inflight)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr,
                                 input logic [15:0] addr, input logic [15:0] wdata);
        cache_MemRead        = rd;
        cache_MemWrite       = wr;
        cache_mem_addr       = addr;
        cache_mem_write_data = wdata;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic writeWord(input logic [15:0] addr, input logic [15:0] data);
        applyStimulus(1'b0, 1'b1, addr, data);
        tick();
        idle();
    endtask

    // Issue one read and follow it cycle by cycle until the single return pulse.
    task automatic expectRead(input string tag, input logic [15:0] addr, input logic [15:0] exp);
        applyStimulus(1'b1, 1'b0, addr, 16'h0);
        tick();
        idle();
        for (int c = 1; c < int'(LAT); c++) begin
            checkOutput({tag, " early valid"}, MemDataValid, 0);
            checkOutput({tag, " inflight"}, rd_inflight, 1);
            tick();
        end
        checkOutput({tag, " pulse"}, MemDataValid, 1);
        checkOutput({tag, " data"}, mem_read_data, exp);
        tick();
        checkOutput({tag, " pulse end"}, MemDataValid, 0);
        checkOutput({tag, " inflight drained"}, rd_inflight, 0);
        checkOutput({tag, " data hold"}, mem_read_data, exp);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pulses;
        int peak;
        logic expValid;

        // Reset state
        #2 rst = 1'b0;
        repeat (3) tick();
        checkOutput("reset valid", MemDataValid, 0);
        checkOutput("reset data", mem_read_data, 16'h0000);
        checkOutput("reset inflight", rd_inflight, 0);
        rst = 1'b1;
        tick();

        // Single read
        writeWord(16'h0010, 16'hBEEF);
        expectRead("single", 16'h0010, 16'hBEEF);

        // Block fill of eight words
        for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
            writeWord(16'h0200 + 16'(2 * i), 16'h1000 + 16'(i));
        end
        pulses = 0;
        peak = 0;
        for (int j = 0; j < WORDS_PER_BLOCK + int'(LAT); j++) begin
            if (j < WORDS_PER_BLOCK) begin
                applyStimulus(1'b1, 1'b0, 16'h0200 + 16'(2 * j), 16'h0);
            end else begin
                idle();
            end
            tick();
            if (int'(rd_inflight) > peak) peak = int'(rd_inflight);
            expValid = (j >= int'(LAT) - 1) && (j < WORDS_PER_BLOCK + int'(LAT) - 1);
            checkOutput($sformatf("fill valid c%0d", j), MemDataValid, expValid);
            if (expValid) begin
                checkOutput($sformatf("fill data c%0d", j), mem_read_data, 16'h1000 + 16'(pulses));
                pulses++;
            end
        end
        idle();
        checkOutput("fill peak inflight", peak, 4);
        checkOutput("fill inflight end", rd_inflight, 0);

        // Simultaneous read and write: read-first
        writeWord(16'h0040, 16'h1111);
        applyStimulus(1'b1, 1'b1, 16'h0040, 16'h2222);
        tick();
        idle();
        repeat (int'(LAT) - 1) tick();
        checkOutput("rw same-cycle pulse", MemDataValid, 1);
        checkOutput("rw same-cycle data", mem_read_data, 16'h1111);
        tick();

        // A write alone never pulses
        applyStimulus(1'b0, 1'b1, 16'h0042, 16'h5555);
        tick();
        idle();
        for (int c = 0; c < 5; c++) begin
            checkOutput($sformatf("write-only valid c%0d", c), MemDataValid, 0);
            checkOutput($sformatf("write-only inflight c%0d", c), rd_inflight, 0);
            tick();
        end
        expectRead("rw later read", 16'h0040, 16'h2222);

        // Write after an accepted read does not disturb the in-flight word
        applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0);
        tick();
        applyStimulus(1'b0, 1'b1, 16'h0040, 16'h3333);
        tick();
        idle();
        repeat (int'(LAT) - 2) tick();
        checkOutput("inflight capture pulse", MemDataValid, 1);
        checkOutput("inflight capture data", mem_read_data, 16'h2222);
        tick();

        // Reset in the middle of a three-read burst
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 16'h0200 + 16'(2 * i), 16'h0);
            tick();
        end
        idle();
        tick();
        rst = 1'b0;
        #1;
        checkOutput("midfill reset valid", MemDataValid, 0);
        checkOutput("midfill reset data", mem_read_data, 16'h0000);
        checkOutput("midfill reset inflight", rd_inflight, 0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            checkOutput($sformatf("post-reset valid c%0d", c), MemDataValid, 0);
            checkOutput($sformatf("post-reset inflight c%0d", c), rd_inflight, 0);
        end
        expectRead("survive 0200", 16'h0200, 16'h1000);
        expectRead("survive 0040", 16'h0040, 16'h3333);

        // Odd address aliases the even word
        writeWord(16'hFFFE, 16'hABCD);
        expectRead("odd addr", 16'hFFFF, 16'hABCD);
        writeWord(16'h0011, 16'h7777);
        expectRead("odd write", 16'h0010, 16'h7777);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Main-memory responder on the far end of the cache/memory interface.
- Accepts word reads and writes issued by a cache controller (I-cache or D-cache).
- Returns read data after a fixed pipelined latency, as a one-cycle valid pulse per word, so a cache block fill can stream 8 consecutive words.
- One instance per cache in the system-level memory model.

Parameters:
- ADDR_W, 16, byte address width; bit 0 is ignored because accesses are 16-bit words.
- DATA_W, 16, word width.
- DEPTH_W, 15, log2 of the number of words stored; word index = addr[DEPTH_W:1].
- LATENCY, 4, cycles from read acceptance to the data-valid pulse; legal range 1..8.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- cache_MemRead  in  1  read request; sampled every cycle, one word per asserted cycle.
- cache_MemWrite  in  1  write request; sampled every cycle.
- cache_mem_addr  in  ADDR_W  byte address for the read and/or write.
- cache_mem_write_data  in  DATA_W  write data.
- MemDataValid  out  1  read data valid; one pulse per accepted read.
- mem_read_data  out  DATA_W  read data; meaningful only while MemDataValid = 1.
- rd_inflight  out  4  number of accepted reads not yet returned (0..LATENCY).

Behaviour:
- Reset (rst = 0, asynchronous):
  - MemDataValid = 0, mem_read_data = 0, rd_inflight = 0.
  - All pipeline stage valids cleared.
  - Storage array is NOT cleared; contents survive reset.
- No backpressure: a request is accepted on every cycle it is presented.
- Read:
  - When cache_MemRead = 1 at edge T, array[addr[DEPTH_W:1]] is sampled at T.
  - The sampled word travels down a LATENCY-deep valid/data delay line.
  - MemDataValid = 1 and mem_read_data = that word during the cycle after edge T+LATENCY-1; for LATENCY = 4 the valid cycle is T+4 (1 = next cycle).
  - Back-to-back reads on consecutive cycles return on consecutive cycles, in issue order.
- Write:
  - When cache_MemWrite = 1 at edge T, the array word is updated at T.
  - No response pulse; a write never raises MemDataValid.
- Read and write in the same cycle: both are accepted at the same address, with read-first semantics.
  - The read returns the pre-write value.
  - The array holds the new value afterwards.
- A write issued after a read is accepted does not alter that read's in-flight data, since data is captured at issue.
- Address 0xFFFF maps to the same word as 0xFFFE. Addresses beyond 2^DEPTH_W words wrap by truncation of the upper bits.
- rd_inflight:
  - Increments on an accepted read.
  - Decrements on a valid pulse.
  - Unchanged when both happen in the same cycle.
  - Can never exceed LATENCY.
- Reset mid-fill: all in-flight reads are discarded and no stale valid pulse appears after rst deasserts. The controller must reissue the fill.
- Output timing: mem_read_data is driven from the last pipeline register (registered output); it holds its last value when MemDataValid = 0.
- Invalid LATENCY: an elaboration-time check fails if LATENCY is outside 1..8.
- No state machine beyond the delay line. Occupancy is tracked solely by the stage valid bits plus the rd_inflight counter. An assertion requires that rd_inflight equals the popcount of the stage valids.

Decomposition:
- Shared package mem_if_pkg holds:
  - ADDR_W/DATA_W defaults.
  - WORDS_PER_BLOCK = 8.
  - MAX_LATENCY = 8.
  - Latency type sized to 4 bits, shared by the cache fill controller and the bench.
- Sub-module mem_resp_pipe: parameterised LATENCY-stage valid+data shift register with async active-low clear, instanced once.
- The top level holds the storage array, write port and occupancy counter.

Test Plan:
1. Reset value: hold rst = 0 for 3 cycles → MemDataValid = 0, mem_read_data = 0x0000, rd_inflight = 0.
2. Single read, LATENCY = 4:
   - Preload word at 0x0010 with 0xBEEF; read 0x0010 at cycle 10.
   - → MemDataValid high only in cycle 14 with 0xBEEF; rd_inflight = 1 in cycles 11-13, then 0.
3. Block fill:
   - Reads of 0x0200, 0x0202 … 0x020E on 8 consecutive cycles, array preloaded with 0x1000 + index.
   - → 8 consecutive valid pulses returning 0x1000 … 0x1007 in order; rd_inflight peaks at 4.
4. Simultaneous read and write:
   - 0x0040 holds 0x1111; in one cycle, read and write 0x0040 with 0x2222.
   - → the pulse returns 0x1111; a later read returns 0x2222; no pulse is generated for the write alone.
5. Reset mid-fill:
   - Assert rst for 1 cycle two cycles after a 3-read burst.
   - → no MemDataValid pulse afterwards, rd_inflight = 0, and earlier-written data is still readable.
6. Odd address and wrap:
   - Write 0xABCD to 0xFFFE, then read 0xFFFF.
   - → returns 0xABCD after LATENCY cycles.
